// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifu_pkg;
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } ifu_state_e;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
endpackage

// File: rtl/ifu_hold_buf.sv
// One-entry {instr, pc} buffer that parks a response arriving during a load-use stall.
module ifu_hold_buf (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_wr,
   input  logic [31:0] i_wr_instr,
   input  logic [63:0] i_wr_pc,
   input  logic        i_rd,
   input  logic        i_clr,
   output logic        o_valid,
   output logic [31:0] o_instr,
   output logic [63:0] o_pc
);
   logic        r_valid;
   logic [31:0] r_instr;
   logic [63:0] r_pc;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
      end else begin
         if (i_clr)     r_valid <= 1'b0;
         else if (i_wr) r_valid <= 1'b1;
         else if (i_rd) r_valid <= 1'b0;
         if (i_wr) begin
            r_instr <= i_wr_instr;
            r_pc    <= i_wr_pc;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;
endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC, single-outstanding imem requests and the IF/ID register.
// Optional performance counters are built when IFU_PERF_EN is defined.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [63:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ld_hz_nop,
   input  logic        flush_nop,
   input  logic [63:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic [31:0] ifu_instr,
   output logic [63:0] ifu_pc,
   output logic [63:0] ifu_snxt_pc
`ifdef IFU_PERF_EN
   ,
   output logic [63:0] perf_fetch_cnt,
   output logic [63:0] perf_stall_cnt
`endif
);
   ifu_state_e  r_state, w_state_nxt;
   logic [63:0] r_pc, r_inflight_pc;
   logic [31:0] r_id_instr;
   logic [63:0] r_id_pc, r_id_snxt;
   logic        w_hs, w_resp_take, w_hold_wr, w_hold_rd;
   logic        w_hold_valid;
   logic [31:0] w_hold_instr;
   logic [63:0] w_hold_pc;

   assign imem_req_valid = (r_state == S_REQ) && !w_hold_valid;
   assign imem_req_addr  = r_pc;
   assign w_hs           = imem_req_valid && imem_req_ready;
   // A response is usable only if it answers a live request and no flush kills it.
   assign w_resp_take    = (r_state == S_WAIT) && imem_resp_valid && !flush_nop;
   assign w_hold_wr      = w_resp_take && ld_hz_nop;
   assign w_hold_rd      = !flush_nop && !ld_hz_nop && w_hold_valid;

   ifu_hold_buf u_hold (
      .clk        (clk),
      .rstn       (rstn),
      .i_wr       (w_hold_wr),
      .i_wr_instr (imem_resp_data),
      .i_wr_pc    (r_inflight_pc),
      .i_rd       (w_hold_rd),
      .i_clr      (flush_nop),
      .o_valid    (w_hold_valid),
      .o_instr    (w_hold_instr),
      .o_pc       (w_hold_pc)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_REQ;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_REQ:   if (w_hs) w_state_nxt = flush_nop ? S_DROP : S_WAIT;
         S_WAIT: begin
            if (imem_resp_valid) w_state_nxt = S_REQ;
            else if (flush_nop)  w_state_nxt = S_DROP;
         end
         S_DROP:  if (imem_resp_valid) w_state_nxt = S_REQ;
         default: w_state_nxt = S_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc          <= RESET_PC;
         r_inflight_pc <= '0;
      end else begin
         if (flush_nop) r_pc <= redirect_pc;
         else if (w_hs) r_pc <= r_pc + 64'd4;
         if (w_hs) r_inflight_pc <= r_pc;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_id_instr <= NOP_INSTR;
         r_id_pc    <= '0;
         r_id_snxt  <= '0;
      end else if (flush_nop) begin
         r_id_instr <= NOP_INSTR;
         r_id_pc    <= '0;
         r_id_snxt  <= '0;
      end else if (!ld_hz_nop) begin
         if (w_hold_valid) begin
            r_id_instr <= w_hold_instr;
            r_id_pc    <= w_hold_pc;
            r_id_snxt  <= w_hold_pc + 64'd4;
         end else if (w_resp_take) begin
            r_id_instr <= imem_resp_data;
            r_id_pc    <= r_inflight_pc;
            r_id_snxt  <= r_inflight_pc + 64'd4;
         end else begin
            r_id_instr <= NOP_INSTR;
            r_id_pc    <= '0;
            r_id_snxt  <= '0;
         end
      end
   end

   assign ifu_instr   = r_id_instr;
   assign ifu_pc      = r_id_pc;
   assign ifu_snxt_pc = r_id_snxt;

`ifdef IFU_PERF_EN
   logic [63:0] r_perf_fetch, r_perf_stall;
   logic        w_fetch_evt;

   assign w_fetch_evt = !flush_nop && !ld_hz_nop && (w_hold_valid || w_resp_take);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_perf_fetch <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_fetch_evt) r_perf_fetch <= r_perf_fetch + 64'd1;
         if (ld_hz_nop)   r_perf_stall <= r_perf_stall + 64'd1;
      end
   end

   assign perf_fetch_cnt = r_perf_fetch;
   assign perf_stall_cnt = r_perf_stall;
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch with a transaction-level reference model and a memory responder.
module tb_ifu_fetch;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [63:0] RPC = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        ld_hz_nop = 1'b0, flush_nop = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        imem_req_valid, imem_req_ready = 1'b0;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic [31:0] ifu_instr;
   logic [63:0] ifu_pc, ifu_snxt_pc;
`ifdef IFU_PERF_EN
   logic [63:0] perf_fetch_cnt, perf_stall_cnt;
`endif

   ifu_fetch dut (
      .clk             (clk),
      .rstn            (rstn),
      .ld_hz_nop       (ld_hz_nop),
      .flush_nop       (flush_nop),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .ifu_instr       (ifu_instr),
      .ifu_pc          (ifu_pc),
      .ifu_snxt_pc     (ifu_snxt_pc)
`ifdef IFU_PERF_EN
      ,
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_stall_cnt  (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;

   // reference model: expected IF/ID, next fetch PC, outstanding request, held word
   logic [31:0] e_instr;
   logic [63:0] e_pc, e_snxt, m_pc, m_out_pc, m_held_pc, e_fetch, e_stall;
   logic        m_busy, m_drop, m_held_v;
   logic [31:0] m_held_i;
   // memory responder
   logic        r_pend;
   logic [63:0] r_addr;
   int          r_due;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == RPC) return 32'h0010_0093;
      return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      e_instr = NOP; e_pc = '0; e_snxt = '0; m_pc = RPC;
      m_busy = 1'b0; m_drop = 1'b0; m_held_v = 1'b0;
      m_out_pc = '0; m_held_pc = '0; m_held_i = '0;
      e_fetch = '0; e_stall = '0;
      r_pend = 1'b0; r_addr = '0; r_due = 0;
   endtask

   // Asserts reset mid-cycle, checks the asynchronous reset values, and
   // releases it so the caller sits one time unit after the edge of cycle 1.
   task automatic do_reset();
      ld_hz_nop = 1'b0; flush_nop = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
      rstn = 1'b0;
      #1;
      chk("rst_instr", {32'h0, ifu_instr}, {32'h0, NOP});
      chk("rst_pc", ifu_pc, 64'h0);
      chk("rst_snxt", ifu_snxt_pc, 64'h0);
      chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("rst_req_addr", imem_req_addr, 64'h8000_0000);
`ifdef IFU_PERF_EN
      chk("rst_perf_fetch", perf_fetch_cnt, 64'h0);
      chk("rst_perf_stall", perf_stall_cnt, 64'h0);
`endif
      model_reset();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      cyc = 1;
   endtask

   // One clock cycle: check registered outputs, drive inputs, check the request
   // channel, advance model and responder, then move to the next cycle.
   task automatic cycle(input logic ld, input logic fl, input logic [63:0] rpc,
                        input logic rdy, input int kmin, input int kmax);
      logic        exp_v, hs, live, rv;
      logic [31:0] rd;
      chk("ifu_instr", {32'h0, ifu_instr}, {32'h0, e_instr});
      chk("ifu_pc", ifu_pc, e_pc);
      chk("ifu_snxt_pc", ifu_snxt_pc, e_snxt);
`ifdef IFU_PERF_EN
      chk("perf_fetch", perf_fetch_cnt, e_fetch);
      chk("perf_stall", perf_stall_cnt, e_stall);
`endif
      ld_hz_nop = ld; flush_nop = fl; redirect_pc = rpc; imem_req_ready = rdy;
      imem_resp_valid = r_pend && (cyc == r_due);
      imem_resp_data  = imem_resp_valid ? mem_word(r_addr) : $urandom;
      #1;
      exp_v = !m_busy && !m_held_v;
      chk("req_valid", {63'h0, imem_req_valid}, {63'h0, exp_v});
      if (exp_v) chk("req_addr", imem_req_addr, m_pc);
      rv = imem_resp_valid; rd = imem_resp_data;
      hs = exp_v && rdy;
      live = rv && m_busy && !m_drop && !fl;
      if (fl) begin
         e_instr = NOP; e_pc = '0; e_snxt = '0; m_held_v = 1'b0;
      end else if (ld) begin
         if (live) begin
            m_held_v = 1'b1; m_held_i = rd; m_held_pc = m_out_pc;
         end
      end else if (m_held_v) begin
         e_instr = m_held_i; e_pc = m_held_pc; e_snxt = m_held_pc + 64'd4;
         m_held_v = 1'b0; e_fetch++;
      end else if (live) begin
         e_instr = rd; e_pc = m_out_pc; e_snxt = m_out_pc + 64'd4; e_fetch++;
      end else begin
         e_instr = NOP; e_pc = '0; e_snxt = '0;
      end
      if (ld) e_stall++;
      if (rv) m_busy = 1'b0;
      else if (fl && m_busy) m_drop = 1'b1;
      if (hs) begin
         m_busy = 1'b1; m_drop = fl; m_out_pc = m_pc;
      end
      m_pc = fl ? rpc : (hs ? m_pc + 64'd4 : m_pc);
      if (rv) r_pend = 1'b0;
      if (imem_req_valid && rdy) begin
         r_pend = 1'b1; r_addr = imem_req_addr;
         r_due = cyc + $urandom_range(kmax, kmin);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      #2;
      do_reset();
      // zero-wait fetch of the reset vector
      cycle(0, 0, 0, 1, 1, 1);
      cycle(0, 0, 0, 1, 1, 1);
      chk("first_instr", {32'h0, ifu_instr}, 64'h0010_0093);
      chk("first_pc", ifu_pc, 64'h8000_0000);
      chk("first_snxt", ifu_snxt_pc, 64'h8000_0004);
      // ready low: request holds, bubbles flow
      repeat (3) cycle(0, 0, 0, 0, 1, 1);
      chk("stall_rdy_addr", imem_req_addr, 64'h8000_0004);
      chk("stall_rdy_instr", {32'h0, ifu_instr}, {32'h0, NOP});
      // load-use stall while the response arrives
      cycle(0, 0, 0, 1, 1, 1);
      cycle(1, 0, 0, 1, 1, 1);
      cycle(1, 0, 0, 1, 1, 1);
      chk("held_no_req", {63'h0, imem_req_valid}, 64'h0);
      cycle(0, 0, 0, 1, 1, 1);
      chk("drain_instr", {32'h0, ifu_instr}, 64'h9357_9BDB);
      chk("drain_pc", ifu_pc, 64'h8000_0004);
      chk("drain_snxt", ifu_snxt_pc, 64'h8000_0008);
`ifdef IFU_PERF_EN
      chk("perf_fetch_dir", perf_fetch_cnt, 64'd2);
      chk("perf_stall_dir", perf_stall_cnt, 64'd2);
`endif
      // flush while waiting on a two-cycle response
      cycle(0, 0, 0, 1, 2, 2);
      cycle(0, 1, 64'h8000_0100, 1, 1, 1);
      chk("flush_instr", {32'h0, ifu_instr}, {32'h0, NOP});
      chk("flush_pc", ifu_pc, 64'h0);
      cycle(0, 0, 0, 1, 1, 1);
      chk("drop_instr", {32'h0, ifu_instr}, {32'h0, NOP});
      chk("redir_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("redir_addr", imem_req_addr, 64'h8000_0100);
      // flush and stall together with the hold buffer full
      cycle(0, 0, 0, 1, 1, 1);
      cycle(1, 0, 0, 1, 1, 1);
      cycle(1, 1, 64'h8000_0200, 1, 1, 1);
      chk("fs_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("fs_addr", imem_req_addr, 64'h8000_0200);
      chk("fs_instr", {32'h0, ifu_instr}, {32'h0, NOP});
      cycle(0, 0, 0, 0, 1, 1);
      chk("fs_no_held_instr", {32'h0, ifu_instr}, {32'h0, NOP});
      chk("fs_no_held_pc", ifu_pc, 64'h0);
      // random traffic, including redirects near the top of the address space
      for (int i = 0; i < 3000; i++) begin
         logic        ld, fl, rdy;
         logic [63:0] rpc;
         ld  = ($urandom_range(3, 0) == 0);
         fl  = ($urandom_range(15, 0) == 0);
         rdy = ($urandom_range(9, 0) < 7);
         rpc = ($urandom_range(3, 0) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                          : ({$urandom, $urandom} & ~64'h3);
         cycle(ld, fl, fl ? rpc : 64'h0, rdy, 1, 4);
      end
      // reset in the middle of traffic, then more random traffic
      #1;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         logic ld, fl, rdy;
         ld  = ($urandom_range(3, 0) == 0);
         fl  = ($urandom_range(15, 0) == 0);
         rdy = ($urandom_range(9, 0) < 7);
         cycle(ld, fl, fl ? ({$urandom, $urandom} & ~64'h3) : 64'h0, rdy, 1, 3);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
